// File: rtl/field_extract_pipe.sv
// Registered static/dynamic field extractor with valid/ready handshake,
// selectable index-overflow handling and a saturating overflow counter.
module field_extract_pipe #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned FIELD_W  = 3,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned STAT_MSB = 7,
  parameter int unsigned STAT_LSB = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            data_in,
  input  logic [IDX_W-1:0]             idx_in,
  input  logic [1:0]                   mode_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [STAT_MSB-STAT_LSB:0]   stat_out,
  output logic [FIELD_W-1:0]           dyn_out,
  output logic                         ovf_out,
  input  logic                         clr_cnt,
  output logic [CNT_W-1:0]             ovf_cnt
);

  localparam int unsigned   LIM   = DATA_W - FIELD_W;
  localparam int unsigned   SEL_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W:0] LIM_V = (IDX_W+1)'(LIM);

  typedef enum logic [1:0] {
    MODE_ZERO    = 2'd0,
    MODE_WRAP    = 2'd1,
    MODE_CLAMP   = 2'd2,
    MODE_PARTIAL = 2'd3
  } mode_e;

  mode_e                       w_mode;
  logic                        w_accept;
  logic                        w_ovf;
  logic [FIELD_W-1:0]          w_dyn;
  logic [31:0]                 w_pos;
  logic                        w_en;

  logic                        r_valid;
  logic [STAT_MSB-STAT_LSB:0]  r_stat;
  logic [FIELD_W-1:0]          r_dyn;
  logic                        r_ovf;
  logic [CNT_W-1:0]            r_cnt;

  assign w_mode   = mode_e'(mode_in);
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_ovf    = ({1'b0, idx_in} > LIM_V);

  // Per-bit source position; w_en gates bits that must read as zero.
  always_comb begin
    w_dyn = '0;
    w_pos = '0;
    w_en  = 1'b0;
    for (int unsigned i = 0; i < FIELD_W; i++) begin
      w_en  = 1'b1;
      w_pos = 32'(idx_in) + i;
      if (w_ovf) begin
        case (w_mode)
          MODE_ZERO:    w_en  = 1'b0;
          MODE_WRAP:    w_pos = w_pos % DATA_W;
          MODE_CLAMP:   w_pos = LIM + i;
          MODE_PARTIAL: w_en  = (w_pos < DATA_W);
          default:      w_en  = 1'b0;
        endcase
      end
      w_dyn[i] = w_en & data_in[w_pos[SEL_W-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_stat  <= '0;
      r_dyn   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_stat  <= data_in[STAT_MSB:STAT_LSB];
      r_dyn   <= w_dyn;
      r_ovf   <= w_ovf;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // A clear coinciding with an accepted overflow keeps that event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr_cnt) begin
      r_cnt <= (w_accept && w_ovf) ? CNT_W'(1) : '0;
    end else if (w_accept && w_ovf && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_valid;
  assign stat_out  = r_stat;
  assign dyn_out   = r_dyn;
  assign ovf_out   = r_ovf;
  assign ovf_cnt   = r_cnt;

endmodule

// File: tb/tb_field_extract_pipe.sv
// Bench for field_extract_pipe: default 8-bit instance plus a 16/5/5 instance,
// both checked every cycle against a shift/mask reference model.
module tb_field_extract_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid [2];
  logic        out_ready[2];
  logic        clr      [2];
  logic [15:0] data     [2];
  logic [4:0]  idx      [2];
  logic [1:0]  mode     [2];

  logic        in_ready [2];
  logic        out_valid[2];
  logic        ovf      [2];
  logic [7:0]  cnt      [2];
  logic [15:0] stat     [2];
  logic [15:0] dyn      [2];

  logic [3:0]  stat8;
  logic [2:0]  dyn8;
  logic [8:0]  stat16;
  logic [4:0]  dyn16;

  int unsigned DW[2] = '{8, 16};
  int unsigned FW[2] = '{3, 5};
  int unsigned SM[2] = '{7, 11};
  int unsigned SL[2] = '{4, 3};

  int n_cmp = 0;
  int n_bad = 0;

  field_extract_pipe u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_in(data[0][7:0]), .idx_in(idx[0][3:0]), .mode_in(mode[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .stat_out(stat8),
    .dyn_out(dyn8), .ovf_out(ovf[0]), .clr_cnt(clr[0]), .ovf_cnt(cnt[0])
  );

  field_extract_pipe #(
    .DATA_W(16), .FIELD_W(5), .IDX_W(5), .STAT_MSB(11), .STAT_LSB(3), .CNT_W(8)
  ) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_in(data[1]), .idx_in(idx[1]), .mode_in(mode[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .stat_out(stat16),
    .dyn_out(dyn16), .ovf_out(ovf[1]), .clr_cnt(clr[1]), .ovf_cnt(cnt[1])
  );

  assign stat[0] = 16'(stat8);
  assign dyn[0]  = 16'(dyn8);
  assign stat[1] = 16'(stat16);
  assign dyn[1]  = 16'(dyn16);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_dyn(input logic [15:0] d, input int unsigned ix,
                                          input int unsigned md, input int unsigned dw,
                                          input int unsigned fw);
    logic [63:0] dd, fm;
    int unsigned lim;
    lim = dw - fw;
    fm  = (64'd1 << fw) - 64'd1;
    dd  = 64'(d) & ((64'd1 << dw) - 64'd1);
    if (ix <= lim) return 16'((dd >> ix) & fm);
    case (md)
      0:       return 16'd0;
      1:       return 16'((((dd << dw) | dd) >> (ix % dw)) & fm);
      2:       return 16'((dd >> lim) & fm);
      default: return 16'((dd >> ix) & fm);
    endcase
  endfunction

  function automatic logic [15:0] ref_stat(input logic [15:0] d, input int unsigned msb,
                                           input int unsigned lsb);
    return 16'((32'(d) >> lsb) & ((32'd1 << (msb - lsb + 1)) - 32'd1));
  endfunction

  // Reference model state: the result currently owed downstream.
  logic        m_valid[2];
  logic [15:0] m_stat [2];
  logic [15:0] m_dyn  [2];
  logic        m_ovf  [2];
  logic [7:0]  m_cnt  [2];

  function automatic logic acc_of(input int k);
    return in_valid[k] && (!m_valid[k] || out_ready[k]);
  endfunction

  function automatic logic ovf_of(input int k);
    return 32'(idx[k]) > (DW[k] - FW[k]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_valid[k] <= 1'b0;
        m_stat[k]  <= '0;
        m_dyn[k]   <= '0;
        m_ovf[k]   <= 1'b0;
        m_cnt[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (clr[k])
          m_cnt[k] <= (acc_of(k) && ovf_of(k)) ? 8'd1 : 8'd0;
        else if (acc_of(k) && ovf_of(k) && m_cnt[k] < 8'd255)
          m_cnt[k] <= m_cnt[k] + 8'd1;
        if (acc_of(k)) begin
          m_valid[k] <= 1'b1;
          m_stat[k]  <= ref_stat(data[k], SM[k], SL[k]);
          m_dyn[k]   <= ref_dyn(data[k], 32'(idx[k]), 32'(mode[k]), DW[k], FW[k]);
          m_ovf[k]   <= ovf_of(k);
        end else if (out_ready[k]) begin
          m_valid[k] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("in_ready[%0d]", k), 16'(in_ready[k]), 16'(!m_valid[k] || out_ready[k]));
      chk($sformatf("out_valid[%0d]", k), 16'(out_valid[k]), 16'(m_valid[k]));
      chk($sformatf("ovf_cnt[%0d]", k), 16'(cnt[k]), 16'(m_cnt[k]));
      if (m_valid[k]) begin
        chk($sformatf("stat[%0d]", k), stat[k], m_stat[k]);
        chk($sformatf("dyn[%0d]", k), dyn[k], m_dyn[k]);
        chk($sformatf("ovf[%0d]", k), 16'(ovf[k]), 16'(m_ovf[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [7:0] d, input logic [3:0] ix,
                        input logic [1:0] md);
    in_valid[0] = v;
    data[0]     = 16'(d);
    idx[0]      = 5'(ix);
    mode[0]     = md;
  endtask

  typedef struct {
    logic [3:0] ix;
    logic [1:0] md;
    logic [2:0] exp;
  } vec_t;

  vec_t ovf_vec[6] = '{
    '{4'd13, 2'd0, 3'b000},
    '{4'd13, 2'd1, 3'b101},
    '{4'd13, 2'd2, 3'b101},
    '{4'd13, 2'd3, 3'b000},
    '{4'd7,  2'd3, 3'b001},
    '{4'd7,  2'd1, 3'b101}
  };

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b1; clr[k] = 1'b0;
      data[k] = '0; idx[k] = '0; mode[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", 16'(out_valid[0]), 16'd0);
    chk("rst_dyn", dyn[0], 16'd0);
    chk("rst_cnt", 16'(cnt[0]), 16'd0);

    // Basic in-range extraction, latency 1.
    drive0(1'b1, 8'hB6, 4'd2, 2'd0);
    step();
    in_valid[0] = 1'b0;
    chk("t1_valid", 16'(out_valid[0]), 16'd1);
    chk("t1_stat", stat[0], 16'hB);
    chk("t1_dyn", dyn[0], 16'b101);
    chk("t1_ovf", 16'(ovf[0]), 16'd0);

    // Overflow modes, back to back.
    foreach (ovf_vec[j]) begin
      drive0(1'b1, 8'hB6, ovf_vec[j].ix, ovf_vec[j].md);
      step();
      chk($sformatf("t2_dyn_%0d", j), dyn[0], 16'(ovf_vec[j].exp));
      chk($sformatf("t2_ovf_%0d", j), 16'(ovf[0]), 16'd1);
    end
    in_valid[0] = 1'b0;
    step();

    // Backpressure: A held while B waits, B taken the cycle out_ready rises.
    out_ready[0] = 1'b0;
    drive0(1'b1, 8'h5A, 4'd0, 2'd0);
    step();
    drive0(1'b1, 8'hC3, 4'd1, 2'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t3_ready_low", 16'(in_ready[0]), 16'd0);
      chk("t3_hold_dyn", dyn[0], 16'b010);
      chk("t3_hold_stat", stat[0], 16'h5);
    end
    out_ready[0] = 1'b1;
    #1 chk("t3_ready_high", 16'(in_ready[0]), 16'd1);
    step();
    in_valid[0] = 1'b0;
    chk("t3_b_dyn", dyn[0], 16'b001);
    chk("t3_b_stat", stat[0], 16'hC);
    step();
    chk("t3_drained", 16'(out_valid[0]), 16'd0);

    // Counter saturation and clear/overflow collision.
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    chk("t4_clr", 16'(cnt[0]), 16'd0);
    drive0(1'b1, 8'hB6, 4'd13, 2'd1);
    repeat (255) step();
    chk("t4_255", 16'(cnt[0]), 16'hFF);
    step();
    chk("t4_sat", 16'(cnt[0]), 16'hFF);
    clr[0] = 1'b1;
    step();
    chk("t4_clr_ovf", 16'(cnt[0]), 16'd1);
    in_valid[0] = 1'b0;
    step();
    clr[0] = 1'b0;
    chk("t4_clr_only", 16'(cnt[0]), 16'd0);

    // Reset while a result is stalled.
    out_ready[0] = 1'b0;
    drive0(1'b1, 8'h3C, 4'd14, 2'd2);
    step();
    in_valid[0] = 1'b0;
    step();
    chk("t5_stalled", 16'(out_valid[0]), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 16'(out_valid[0]), 16'd0);
    chk("t5_rst_cnt", 16'(cnt[0]), 16'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready[0] = 1'b1;
    drive0(1'b1, 8'hB6, 4'd2, 2'd0);
    step();
    in_valid[0] = 1'b0;
    chk("t5_after_valid", 16'(out_valid[0]), 16'd1);
    chk("t5_after_dyn", dyn[0], 16'b101);

    // Random traffic with stalls on both instances.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        out_ready[k] = ($urandom_range(0, 2) != 0);
        clr[k]       = ($urandom_range(0, 31) == 0);
        data[k]      = 16'($urandom);
        idx[k]       = (k == 0) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(0, 31));
        mode[k]      = 2'($urandom_range(0, 3));
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b1;
      clr[k] = 1'b0;
    end
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
